spi_arbiter: RTL and testbench
==============================

# spi_arbiter

Shares one SPI master (8-bit byte engine with `start`/`ready`/`spi_done_tick` handshake) between `NUM_REQ` requesters. Each requester streams a burst of bytes with valid/ready and a `last` marker. The arbiter grants the engine round-robin, holds a per-requester chip select low for the whole burst, and sequences one `start` per byte. Received bytes return tagged with the owner ID. It sits between client blocks (flash/sensor drivers) and the SPI master; the master's own `ss_n_out` stays unused at board level.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `STALL_MAX`, 1024: cycles the owner may leave `req_valid` low mid-burst before the burst is aborted.
- `CS_GAP`, 2: minimum cycles all `cs_n` stay high between bursts (≥1).
- `IDW`, $clog2(NUM_REQ): requester ID width.

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: requester i has a byte to send.
- `req_data` in 8*NUM_REQ: byte of requester i at [8i+7:8i].
- `req_last` in NUM_REQ: byte is the final byte of the burst.
- `req_cpol`, `req_cpha` in NUM_REQ: mode of requester i; sampled at grant only.
- `req_ready` out NUM_REQ: byte of requester i accepted this cycle.
- `grant` out NUM_REQ: one-hot owner, zero when no owner.
- `rx_valid` out 1: one-cycle pulse, byte received.
- `rx_data` out 8: received byte.
- `rx_id` out IDW: owner that received `rx_data`.
- `err_stall` out 1: one-cycle pulse, burst aborted on stall.
- `cs_n` out NUM_REQ: per-requester chip select, active low.
- `spi_din` out 8, `spi_start` out 1, `spi_cpol` out 1, `spi_cpha` out 1: drive the master.
- `spi_dout` in 8, `spi_done_tick` in 1, `spi_ready` in 1: from the master.

## Operation

- States: IDLE, LOAD, WAIT, RELEASE.
- IDLE: if any `req_valid`, select the first set bit at or after `ptr`, wrapping modulo NUM_REQ. Register `grant`, `owner`, `spi_cpol`/`spi_cpha` from that requester, and drive `cs_n[owner]`←0. Go to LOAD.
- LOAD:
  - `req_ready[owner]` = (state==LOAD) && `spi_ready`. This is combinational; all other `req_ready` bits are 0.
  - On `req_valid[owner]&&req_ready[owner]`: register `spi_din`←byte, `last_q`←`req_last[owner]`, `spi_start`←1. Go to WAIT.
- WAIT: on `spi_done_tick`, register `rx_data`←`spi_dout`, `rx_id`←owner, `rx_valid`←1. If `last_q`, go to RELEASE; otherwise return to LOAD.
- RELEASE:
  - All `cs_n`←1 and `grant`←0 on entry.
  - `ptr`←(owner+1) mod NUM_REQ.
  - Hold for CS_GAP cycles, then go to IDLE.
- Stall counter:
  - Counts in LOAD while `req_valid[owner]`=0.
  - Does not count while only `spi_ready`=0.
  - Clears on every accepted byte and on leaving LOAD.
  - Reaching STALL_MAX pulses `err_stall` and goes to RELEASE. No `rx_valid` is produced for the aborted byte.
- Other requesters' `req_valid` never interrupt a burst. No preemption.
- `req_cpol`/`req_cpha` changes mid-burst are ignored.
- `req_valid` from a non-owner while in RELEASE is seen only after return to IDLE.

## Timing

- Reset values: state IDLE, `ptr`=0, `grant`=0, `cs_n`=all 1, `spi_start`=0, `spi_din`=0, `spi_cpol`=0, `spi_cpha`=0, `rx_valid`=0, `rx_data`=0, `rx_id`=0, `err_stall`=0, `req_ready`=0.
- `req_valid` rise in IDLE (cycle 0):
  - `grant`/`cs_n` change at edge 1.
  - Earliest `req_ready` is cycle 1.
  - `spi_start` is high exactly during cycle 2.
- `spi_start` is always exactly one cycle wide and is never asserted while `spi_ready`=0.
- `rx_valid` is asserted the cycle after `spi_done_tick`.
- For a non-last byte, `req_ready` for the next byte can occur in that same cycle, provided `spi_ready`=1.
- `cs_n[owner]` rises one cycle after the `rx_valid` cycle of the last byte, or one cycle after `err_stall`. It stays high at least CS_GAP cycles.
- At most one `cs_n` bit is low at any time. `cs_n` is low only for the `grant` bit.
- Reset asserted mid-burst: everything returns to reset values asynchronously. The SPI master shares `rst_n`.

## Test plan

- Single byte: req 0 sends 0xA5 with last=1; slave returns 0x3C.
  - `spi_start` is a single pulse with `spi_din`=0xA5.
  - `rx_valid` with `rx_data`=0x3C, `rx_id`=0.
  - `cs_n[0]` is low for the whole transfer and high CS_GAP cycles afterwards.
- Burst of 3 from req 2 (0x01, 0x02, 0x03 with last): three `start` pulses and three `rx_valid`; `cs_n[2]` stays low continuously across all three bytes.
- Round-robin: reqs 0, 1, 3 valid simultaneously from reset, each a 1-byte burst.
  - Grant order is 0, 1, 3.
  - With req 0 then re-requesting, the next grant after 3 is 0.
  - Never two `cs_n` low at once.
- Mode latch:
  - req 1 with cpol=1, cpha=1 → `spi_cpol`=`spi_cpha`=1 for the burst.
  - Toggling `req_cpol[1]` mid-burst leaves `spi_cpol` unchanged.
- Stall: req 0 sends one non-last byte, then drops `req_valid`.
  - `err_stall` pulses after STALL_MAX cycles.
  - `cs_n[0]`→1 and `grant`→0.
  - A pending req 1 is served next.
- Reset mid-burst: assert `rst_n`=0 during WAIT of byte 2.
  - All outputs take reset values immediately.
  - After release, a new request from req 0 completes normally.

Source files
------------

// File: rtl/spi_arbiter.sv
// ---------------------------------------------------------------------------
// spi_arbiter
//
// Shares one 8-bit SPI byte engine between NUM_REQ requesters. The engine is
// granted round-robin. The owner's chip select stays low for its whole
// burst, and the arbiter issues one spi_start per byte. Received bytes come
// back tagged with the owner ID. If the owner leaves req_valid low for
// STALL_MAX cycles mid-burst, the burst is aborted.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_data/   per-requester byte stream (data at [8i+7:8i]),
//   req_last              with a last-byte marker
//   req_cpol/req_cpha     per-requester SPI mode, sampled only at grant
//   req_ready             byte of requester i accepted this cycle
//   grant                 one-hot owner, zero when there is no owner
//   rx_valid/rx_data/     one-cycle pulse carrying a received byte and
//   rx_id                 the ID of its owner
//   err_stall             one-cycle pulse, burst aborted on stall
//   cs_n                  per-requester chip select, active low
//   spi_din/spi_start/    drive the SPI master
//   spi_cpol/spi_cpha
//   spi_dout/spi_done_tick/spi_ready   returned from the SPI master
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no owner; pick the next requester round-robin from ptr
// LOAD     | owner holds cs_n low; wait for a byte (stall timer runs)
// WAIT     | byte is in flight in the SPI master; wait for spi_done_tick
// RELEASE  | all cs_n high; hold CS_GAP cycles before the next grant
// ---------------------------------------------------------------------------
module spi_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int STALL_MAX = 1024,
    parameter int CS_GAP    = 2,
    parameter int IDW       = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    input  logic [NUM_REQ-1:0]   req_cpol,
    input  logic [NUM_REQ-1:0]   req_cpha,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 rx_valid,
    output logic [7:0]           rx_data,
    output logic [IDW-1:0]       rx_id,
    output logic                 err_stall,
    output logic [NUM_REQ-1:0]   cs_n,
    output logic [7:0]           spi_din,
    output logic                 spi_start,
    output logic                 spi_cpol,
    output logic                 spi_cpha,
    input  logic [7:0]           spi_dout,
    input  logic                 spi_done_tick,
    input  logic                 spi_ready
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam int SW = $clog2(STALL_MAX + 1);
    localparam int GW = $clog2(CS_GAP + 1);

    localparam logic [SW-1:0]      STALL_LOAD = SW'(STALL_MAX - 1);
    localparam logic [GW-1:0]      GAP_LOAD   = GW'(CS_GAP);
    localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);
    localparam logic [IDW-1:0]     LAST_ID    = IDW'(NUM_REQ - 1);

    logic [1:0]     state;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] ptr;
    logic           last_q;
    logic [SW-1:0]  stall_cnt;
    logic [GW-1:0]  gap_cnt;

    logic           sel_valid;
    logic [IDW-1:0] sel_id;
    logic           own_valid;
    logic           own_last;
    logic [7:0]     own_data;
    logic           accept;
    logic [IDW-1:0] ptr_next;

    // Round-robin pick: the first requesting index at or after ptr, with
    // wrap-around. The loop runs from the far end toward ptr, so the nearest
    // candidate is the last assignment and wins.
    always_comb begin
        int idx;
        sel_valid = 1'b0;
        sel_id    = '0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                sel_valid = 1'b1;
                sel_id    = idx[IDW-1:0];
            end
        end
    end

    assign own_valid = req_valid[owner];
    assign own_last  = req_last[owner];
    assign own_data  = req_data[int'(owner)*8 +: 8];
    assign accept    = (state == ST_LOAD) && spi_ready && own_valid;
    assign ptr_next  = (owner == LAST_ID) ? '0 : owner + IDW'(1);

    always_comb begin
        req_ready = '0;
        if (state == ST_LOAD && spi_ready)
            req_ready[owner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            owner     <= '0;
            ptr       <= '0;
            last_q    <= 1'b0;
            stall_cnt <= STALL_LOAD;
            gap_cnt   <= '0;
            grant     <= '0;
            cs_n      <= '1;
            spi_din   <= 8'h00;
            spi_start <= 1'b0;
            spi_cpol  <= 1'b0;
            spi_cpha  <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= 8'h00;
            rx_id     <= '0;
            err_stall <= 1'b0;
        end else begin
            spi_start <= 1'b0;
            rx_valid  <= 1'b0;
            err_stall <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        owner    <= sel_id;
                        grant    <= ONE_HOT0 << sel_id;
                        cs_n     <= ~(ONE_HOT0 << sel_id);
                        spi_cpol <= req_cpol[sel_id];
                        spi_cpha <= req_cpha[sel_id];
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        spi_din   <= own_data;
                        last_q    <= own_last;
                        spi_start <= 1'b1;
                        stall_cnt <= STALL_LOAD;
                        state     <= ST_WAIT;
                    end else if (!own_valid) begin
                        // Only an absent owner byte counts as a stall. A busy
                        // master (spi_ready low) does not.
                        if (stall_cnt == '0) begin
                            err_stall <= 1'b1;
                            stall_cnt <= STALL_LOAD;
                            gap_cnt   <= GAP_LOAD;
                            state     <= ST_RELEASE;
                        end else begin
                            stall_cnt <= stall_cnt - SW'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (spi_done_tick) begin
                        rx_data  <= spi_dout;
                        rx_id    <= owner;
                        rx_valid <= 1'b1;
                        if (last_q) begin
                            gap_cnt <= GAP_LOAD;
                            state   <= ST_RELEASE;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_RELEASE: begin
                    // The first RELEASE edge raises cs_n. The remaining
                    // CS_GAP cycles, plus the IDLE cycle, keep every select
                    // high before the next grant.
                    grant <= '0;
                    cs_n  <= '1;
                    ptr   <= ptr_next;
                    if (gap_cnt == '0)
                        state <= ST_IDLE;
                    else
                        gap_cnt <= gap_cnt - GW'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
module tb_spi_arbiter;

    localparam int N   = 4;
    localparam int SM  = 16;
    localparam int CG  = 2;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_cpol = '0;
    logic [N-1:0]   req_cpha = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           rx_valid;
    logic [7:0]     rx_data;
    logic [IDW-1:0] rx_id;
    logic           err_stall;
    logic [N-1:0]   cs_n;
    logic [7:0]     spi_din;
    logic           spi_start;
    logic           spi_cpol;
    logic           spi_cpha;
    logic [7:0]     spi_dout;
    logic           spi_done_tick;
    logic           spi_ready;

    logic [7:0]     m_din;
    logic [2:0]     m_cnt;

    int total = 0;
    int bad   = 0;

    logic [9:0] exp_tx[$];     // {cpol, cpha, din}
    logic [9:0] exp_rx[$];     // {id, data}
    int         exp_grant[$];

    always #5 clk = ~clk;

    spi_arbiter #(.NUM_REQ(N), .STALL_MAX(SM), .CS_GAP(CG)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_cpol(req_cpol), .req_cpha(req_cpha), .req_ready(req_ready),
        .grant(grant), .rx_valid(rx_valid), .rx_data(rx_data), .rx_id(rx_id),
        .err_stall(err_stall), .cs_n(cs_n),
        .spi_din(spi_din), .spi_start(spi_start), .spi_cpol(spi_cpol),
        .spi_cpha(spi_cpha), .spi_dout(spi_dout),
        .spi_done_tick(spi_done_tick), .spi_ready(spi_ready)
    );

    // SPI master model: a start is accepted when ready. Five cycles later
    // done_tick and ready return together, and the slave answers din ^ 0x99.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_ready     <= 1'b1;
            spi_done_tick <= 1'b0;
            spi_dout      <= 8'h00;
            m_cnt         <= 3'd0;
            m_din         <= 8'h00;
        end else begin
            spi_done_tick <= 1'b0;
            if (spi_start && spi_ready) begin
                spi_ready <= 1'b0;
                m_cnt     <= 3'd4;
                m_din     <= spi_din;
            end else if (!spi_ready) begin
                if (m_cnt == 3'd0) begin
                    spi_done_tick <= 1'b1;
                    spi_dout      <= m_din ^ 8'h99;
                    spi_ready     <= 1'b1;
                end else begin
                    m_cnt <= m_cnt - 3'd1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a start, a
    // received byte or a new grant, and checks chip-select invariants.
    initial begin
        logic         prev_start;
        logic [N-1:0] prev_grant;
        logic [N-1:0] inv_grant;
        logic [N-1:0] g_exp;
        int           gap;
        bit           seen;
        prev_start = 1'b0; prev_grant = '0; gap = 0; seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_start = 1'b0; prev_grant = '0; gap = 0; seen = 1'b0;
            end else begin
                inv_grant = ~grant;
                chk("cs_single_low", 32'($countones(~cs_n) <= 1), 1);
                chk("cs_matches_grant", cs_n, inv_grant);
                if (spi_start) begin
                    chk("start_width", prev_start, 0);
                    chk("start_while_ready", spi_ready, 1);
                    chk("tx_expected", exp_tx.size() != 0, 1);
                    if (exp_tx.size() != 0)
                        chk("tx_byte_mode", {spi_cpol, spi_cpha, spi_din}, exp_tx.pop_front());
                end
                if (rx_valid) begin
                    chk("rx_cs_low", cs_n[rx_id], 0);
                    chk("rx_expected", exp_rx.size() != 0, 1);
                    if (exp_rx.size() != 0)
                        chk("rx_id_data", {rx_id, rx_data}, exp_rx.pop_front());
                end
                if (grant != '0 && prev_grant == '0) begin
                    chk("grant_expected", exp_grant.size() != 0, 1);
                    if (exp_grant.size() != 0) begin
                        g_exp = N'(1) << exp_grant.pop_front();
                        chk("grant_order", grant, g_exp);
                    end
                    if (seen) chk("cs_gap", gap >= CG, 1);
                    seen = 1'b1;
                end
                if (&cs_n) gap++; else gap = 0;
                prev_start = spi_start;
                prev_grant = grant;
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_cs_n"}, cs_n, 4'hF);
        chk({tag, "_start"}, spi_start, 0);
        chk({tag, "_din"}, spi_din, 0);
        chk({tag, "_mode"}, {spi_cpol, spi_cpha}, 0);
        chk({tag, "_rx"}, {rx_valid, rx_id, rx_data}, 0);
        chk({tag, "_err"}, err_stall, 0);
        chk({tag, "_ready"}, req_ready, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0; req_last = '0; req_cpol = '0; req_cpha = '0;
        #1;
        check_reset_vals("reset");
        exp_tx.delete(); exp_rx.delete(); exp_grant.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic xfer(input int id, input logic [7:0] d, input logic last);
        bit ok;
        ok = 1'b0;
        req_data[id*8 +: 8] = d;
        req_last[id]  = last;
        req_valid[id] = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        chk("handshake_in_time", ok, 1);
    endtask

    task automatic burst(input int id, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input int n);
        for (int i = 0; i < n; i++)
            xfer(id, (i == 0) ? b0 : ((i == 1) ? b1 : b2), i == n - 1);
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (exp_tx.size() + exp_rx.size() + exp_grant.size()) != 0; i++)
            @(negedge clk);
        chk("scoreboard_drained", exp_tx.size() + exp_rx.size() + exp_grant.size(), 0);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Single byte with first-transaction latency checks.
        exp_grant.push_back(0);
        exp_tx.push_back({2'b00, 8'hA5});
        exp_rx.push_back({2'd0, 8'h3C});
        req_data[7:0] = 8'hA5; req_last[0] = 1'b1; req_valid[0] = 1'b1;   // cycle 0
        @(negedge clk);
        chk("c0_grant", grant, 0);
        @(negedge clk);
        chk("c1_grant", grant, 4'b0001);
        chk("c1_cs_n", cs_n, 4'b1110);
        chk("c1_req_ready", req_ready, 4'b0001);
        chk("c1_start", spi_start, 0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0; req_last[0] = 1'b0;
        @(negedge clk);
        chk("c2_start", spi_start, 1);
        drain();

        // Burst of three from requester 2.
        exp_grant.push_back(2);
        exp_tx.push_back({2'b00, 8'h01});
        exp_tx.push_back({2'b00, 8'h02});
        exp_tx.push_back({2'b00, 8'h03});
        exp_rx.push_back({2'd2, 8'h98});
        exp_rx.push_back({2'd2, 8'h9B});
        exp_rx.push_back({2'd2, 8'h9A});
        burst(2, 8'h01, 8'h02, 8'h03, 3);
        drain();

        // Round-robin from reset: 0, 1, 3, then 0 again ahead of 1.
        do_reset();
        exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(3);
        exp_grant.push_back(0); exp_grant.push_back(1);
        exp_tx.push_back({2'b00, 8'h10}); exp_tx.push_back({2'b00, 8'h20});
        exp_tx.push_back({2'b00, 8'h30}); exp_tx.push_back({2'b00, 8'h11});
        exp_tx.push_back({2'b00, 8'h21});
        exp_rx.push_back({2'd0, 8'h89}); exp_rx.push_back({2'd1, 8'hB9});
        exp_rx.push_back({2'd3, 8'hA9}); exp_rx.push_back({2'd0, 8'h88});
        exp_rx.push_back({2'd1, 8'hB8});
        fork
            begin burst(0, 8'h10, 8'h00, 8'h00, 1); burst(0, 8'h11, 8'h00, 8'h00, 1); end
            begin burst(1, 8'h20, 8'h00, 8'h00, 1); burst(1, 8'h21, 8'h00, 8'h00, 1); end
            begin burst(3, 8'h30, 8'h00, 8'h00, 1); end
        join
        drain();

        // Mode latch: cpol/cpha sampled at grant, mid-burst toggle ignored.
        req_cpol[1] = 1'b1; req_cpha[1] = 1'b1;
        exp_grant.push_back(1);
        exp_tx.push_back({2'b11, 8'h55}); exp_tx.push_back({2'b11, 8'h66});
        exp_rx.push_back({2'd1, 8'hCC}); exp_rx.push_back({2'd1, 8'hFF});
        fork
            burst(1, 8'h55, 8'h66, 8'h00, 2);
            begin
                for (int i = 0; i < 100 && !spi_start; i++) @(negedge clk);
                req_cpol[1] = 1'b0;
            end
        join
        drain();
        req_cpha[1] = 1'b0;

        // Stall abort, with requester 1 pending.
        do_reset();
        exp_grant.push_back(0); exp_grant.push_back(1);
        exp_tx.push_back({2'b00, 8'h42}); exp_tx.push_back({2'b00, 8'h77});
        exp_rx.push_back({2'd0, 8'hDB}); exp_rx.push_back({2'd1, 8'hEE});
        fork
            begin xfer(0, 8'h42, 1'b0); req_valid[0] = 1'b0; end
            begin repeat (3) @(posedge clk); #1; burst(1, 8'h77, 8'h00, 8'h00, 1); end
            begin
                bit got;
                bit e;
                int n;
                got = 1'b0; e = 1'b0; n = 0;
                for (int i = 0; i < 200 && !got; i++) begin
                    @(negedge clk);
                    if (rx_valid) got = 1'b1;
                end
                chk("stall_rx_seen", got, 1);
                for (int i = 0; i < 100 && !e; i++) begin
                    @(negedge clk);
                    n++;
                    if (err_stall) e = 1'b1;
                end
                chk("stall_cycles", n, SM);
                @(negedge clk);
                chk("stall_pulse_width", err_stall, 0);
                chk("stall_cs_n", cs_n, 4'hF);
                chk("stall_grant", grant, 0);
            end
        join
        drain();

        // Reset during WAIT of byte 2, then a clean transfer.
        exp_grant.push_back(0);
        exp_tx.push_back({2'b00, 8'hC1}); exp_tx.push_back({2'b00, 8'hC2});
        exp_rx.push_back({2'd0, 8'h58});
        xfer(0, 8'hC1, 1'b0);
        xfer(0, 8'hC2, 1'b0);
        repeat (2) @(negedge clk);
        chk("pre_reset_spi_busy", spi_ready, 0);
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        check_reset_vals("midburst");
        exp_tx.delete(); exp_rx.delete(); exp_grant.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_grant.push_back(0);
        exp_tx.push_back({2'b00, 8'hE7});
        exp_rx.push_back({2'd0, 8'h7E});
        burst(0, 8'hE7, 8'h00, 8'h00, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
